// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared types and hex-to-segment decode for the 7-segment scan driver
package sevenseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    // Active-low segment pattern {a,b,c,d,e,f,g} for one hex nibble.
    function automatic seg_t hex2seg_n(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0:    s = 7'h01;
            4'h1:    s = 7'h4F;
            4'h2:    s = 7'h12;
            4'h3:    s = 7'h06;
            4'h4:    s = 7'h4C;
            4'h5:    s = 7'h24;
            4'h6:    s = 7'h20;
            4'h7:    s = 7'h0F;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h04;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h60;
            4'hC:    s = 7'h31;
            4'hD:    s = 7'h42;
            4'hE:    s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sevenseg_prescaler.sv
// rtl/sevenseg_prescaler.sv - digit-slot prescaler with slot tick and anti-ghost blanking window
module sevenseg_prescaler #(
    parameter int DIV       = 10,
    parameter int BLANK_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic in_blank
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_L = CW'(BLANK_CYC);

    logic [CW-1:0] count;

    assign tick     = (count == LAST);
    assign in_blank = (count < BLANK_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// rtl/sevenseg_scan_driver.sv - time-multiplexed N-digit common-anode 7-segment driver
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int N_DIGITS  = 8,
    parameter int CLK_HZ    = 100_000_000,
    parameter int DIGIT_HZ  = 4_000,
    parameter int BLANK_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    lz_blank,
    input  logic                    load,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [N_DIGITS-1:0]     an_n,
    output logic                    frame_done
);

    localparam int DIV = CLK_HZ / DIGIT_HZ;
    localparam int IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic                   tick;
    logic                   in_blank;
    logic [IW-1:0]          idx;
    logic                   wrap;

    logic [4*N_DIGITS-1:0]  pend_value;
    logic [N_DIGITS-1:0]    pend_dp;
    logic [N_DIGITS-1:0]    pend_en;
    logic                   pend_flag;
    logic [4*N_DIGITS-1:0]  act_value;
    logic [N_DIGITS-1:0]    act_dp;
    logic [N_DIGITS-1:0]    act_en;

    logic [3:0]             nib [N_DIGITS];
    logic [N_DIGITS-1:0]    zero_above;
    logic                   run_zero;
    logic                   lz_dark;
    logic [3:0]             cur_nib;

    sevenseg_prescaler #(
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .in_blank (in_blank)
    );

    assign wrap = tick && (idx == IDX_LAST);

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_nib
        assign nib[g] = act_value[4*g +: 4];
    end

    // zero_above[i] = nibbles i..N_DIGITS-1 of the displayed value are all zero
    always_comb begin
        run_zero   = 1'b1;
        zero_above = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run_zero      = run_zero && (nib[i] == 4'h0);
            zero_above[i] = run_zero;
        end
    end

    assign cur_nib = nib[idx];
    assign lz_dark = lz_blank && (idx != '0) && zero_above[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            pend_flag  <= 1'b0;
            act_value  <= '0;
            act_dp     <= '0;
            act_en     <= '0;
            an_n       <= '1;
            seg_n      <= SEG_OFF;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;

            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end

            // Active set only changes at the frame boundary so a frame is never torn.
            if (wrap && load) begin
                act_value <= value;
                act_dp    <= dp_in;
                act_en    <= digit_en;
                pend_flag <= 1'b0;
            end else if (wrap && pend_flag) begin
                act_value <= pend_value;
                act_dp    <= pend_dp;
                act_en    <= pend_en;
                pend_flag <= 1'b0;
            end else if (load) begin
                pend_value <= value;
                pend_dp    <= dp_in;
                pend_en    <= digit_en;
                pend_flag  <= 1'b1;
            end

            if (in_blank) begin
                an_n  <= '1;
                seg_n <= SEG_OFF;
                dp_n  <= 1'b1;
            end else begin
                an_n <= ~(N_DIGITS'(1) << idx);
                if (!act_en[idx]) begin
                    seg_n <= SEG_OFF;
                    dp_n  <= 1'b1;
                end else if (lz_dark) begin
                    seg_n <= SEG_OFF;
                    dp_n  <= ~act_dp[idx];
                end else begin
                    seg_n <= hex2seg_n(cur_nib);
                    dp_n  <= ~act_dp[idx];
                end
            end
        end
    end

endmodule
